// File: rtl/serial_subtractor_32bit_if.sv
// Start/done handshake bundle for the serial subtractor.
// Operands flow master->slave, result and flags flow back.
interface serial_subtractor_32bit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             V;
    logic             Z;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout, V, Z
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout, V, Z
    );
endinterface

// File: rtl/serial_subtractor_32bit.sv
// Multi-cycle subtractor: D = A - B - Bin, SLICE bits per clock,
// LSB slice first, borrow carried between slices in a register.
module serial_subtractor_32bit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input logic                    clk,
    input logic                    rst,
    serial_subtractor_32bit_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic             borrow;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             v_q;
    logic             z_q;

    logic             accept;
    logic             last;
    int               base;
    logic [SLICE-1:0] a_k;
    logic [SLICE-1:0] b_k;
    logic [SLICE:0]   diff;

    // One slice of the ripple: top bit of diff is the outgoing borrow.
    always_comb begin
        accept   = bus.start && (state == IDLE || state == DONE);
        last     = (count == CW'(N - 1));
        base     = int'(count) * SLICE;
        a_k      = a_q[base +: SLICE];
        b_k      = b_q[base +: SLICE];
        diff     = {1'b0, a_k} - {1'b0, b_k} - {{SLICE{1'b0}}, borrow};
        work_nxt = work;
        work_nxt[base +: SLICE] = diff[SLICE-1:0];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            borrow <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            work   <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
        end else if (accept) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            borrow <= bus.Bin;
            count  <= '0;
            work   <= '0;
        end else if (state == RUN) begin
            work   <= work_nxt;
            borrow <= diff[SLICE];
            count  <= last ? '0 : count + CW'(1);
            // Flags use the latched operands; Bin is not part of V.
            if (last) begin
                d_q    <= work_nxt;
                bout_q <= diff[SLICE];
                v_q    <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                        & (work_nxt[WIDTH-1] ^ a_q[WIDTH-1]);
                z_q    <= ~|work_nxt;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.V    = v_q;
    assign bus.Z    = z_q;
endmodule

// File: tb/tb_serial_subtractor_32bit.sv
// Directed and random checks for serial_subtractor_32bit.
// Each scenario task drives stimulus and compares inline.
module tb_serial_subtractor_32bit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    serial_subtractor_32bit_if bus ();

    serial_subtractor_32bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op; returns edges from start edge to done and busy samples.
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic bin, output int edges,
                          output int busy_n);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.Bin   = ~bin;
        edges  = 0;
        busy_n = 0;
        while (!bus.done && edges < 20) begin
            if (bus.busy) busy_n++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.D, bus.Bout, bus.V, bus.Z} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b D=%h Bout=%b V=%b Z=%b want all 0",
                     bus.busy, bus.done, bus.D, bus.Bout, bus.V, bus.Z);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int e, bn;
        launch(32'd5, 32'd3, 1'b0, e, bn);
        checks++;
        if (e !== 8) begin
            errors++;
            $display("FAIL basic_latency got %0d want 8", e);
        end
        checks++;
        if (bn !== 8) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d want 8", bn);
        end
        checks++;
        if (bus.D !== 32'd2) begin
            errors++;
            $display("FAIL basic_D got %h want 00000002", bus.D);
        end
        checks++;
        if ({bus.Bout, bus.V, bus.Z} !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags got %b want 000", {bus.Bout, bus.V, bus.Z});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0",
                     bus.done, bus.busy);
        end
        checks++;
        if (bus.D !== 32'd2) begin
            errors++;
            $display("FAIL basic_hold got %h want 00000002", bus.D);
        end
    endtask

    // Directed table: {A, B, Bin, D, Bout, V, Z}
    task automatic test_directed;
        logic [31:0] ta [6];
        logic [31:0] tb [6];
        logic        tbin [6];
        logic [31:0] td [6];
        logic [2:0]  tf [6];
        int e, bn;
        ta[0] = 32'h0;        tb[0] = 32'h1;        tbin[0] = 0;
        td[0] = 32'hFFFFFFFF; tf[0] = 3'b100;
        ta[1] = 32'h80000000; tb[1] = 32'h1;        tbin[1] = 0;
        td[1] = 32'h7FFFFFFF; tf[1] = 3'b010;
        ta[2] = 32'h7FFFFFFF; tb[2] = 32'hFFFFFFFF; tbin[2] = 0;
        td[2] = 32'h80000000; tf[2] = 3'b110;
        ta[3] = 32'h12345678; tb[3] = 32'h12345678; tbin[3] = 0;
        td[3] = 32'h0;        tf[3] = 3'b001;
        ta[4] = 32'h12345678; tb[4] = 32'h12345678; tbin[4] = 1;
        td[4] = 32'hFFFFFFFF; tf[4] = 3'b100;
        ta[5] = 32'h0000F000; tb[5] = 32'h00000FFF; tbin[5] = 1;
        td[5] = 32'h0000E000; tf[5] = 3'b000;
        for (int i = 0; i < 6; i++) begin
            launch(ta[i], tb[i], tbin[i], e, bn);
            checks++;
            if (e !== 8) begin
                errors++;
                $display("FAIL dir%0d_latency got %0d want 8", i, e);
            end
            checks++;
            if (bus.D !== td[i]) begin
                errors++;
                $display("FAIL dir%0d_D got %h want %h", i, bus.D, td[i]);
            end
            checks++;
            if ({bus.Bout, bus.V, bus.Z} !== tf[i]) begin
                errors++;
                $display("FAIL dir%0d_flags BoutVZ got %b want %b",
                         i, {bus.Bout, bus.V, bus.Z}, tf[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        int e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 32'd100;
        bus.B     = 32'd1;
        bus.Bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.A     = 32'd7;
        bus.B     = 32'd9;
        bus.Bin   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e = 4;
        while (!bus.done && e < 20) begin
            @(posedge clk);
            #1;
            e++;
        end
        checks++;
        if (e !== 8) begin
            errors++;
            $display("FAIL ignore_latency got %0d want 8", e);
        end
        checks++;
        if ({bus.Bout, bus.D} !== {1'b0, 32'd99}) begin
            errors++;
            $display("FAIL ignore_result got Bout=%b D=%h want 0 00000063",
                     bus.Bout, bus.D);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_no_restart got busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back;
        int e, bn;
        launch(32'h00001000, 32'h00000001, 1'b0, e, bn);
        checks++;
        if (bus.D !== 32'h00000FFF) begin
            errors++;
            $display("FAIL b2b_first_D got %h want 00000FFF", bus.D);
        end
        bus.start = 1'b1;
        bus.A     = 32'h00000003;
        bus.B     = 32'h00000005;
        bus.Bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e = 1;
        while (!bus.done && e < 30) begin
            @(posedge clk);
            #1;
            e++;
        end
        checks++;
        if (e !== 9) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want 9", e);
        end
        checks++;
        if ({bus.Bout, bus.D} !== {1'b1, 32'hFFFFFFFE}) begin
            errors++;
            $display("FAIL b2b_second got Bout=%b D=%h want 1 FFFFFFFE",
                     bus.Bout, bus.D);
        end
    endtask

    task automatic test_reset_mid_run;
        int seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 32'h0F0F0F0F;
        bus.B     = 32'h01010101;
        bus.Bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.D, bus.Bout, bus.V, bus.Z} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got busy=%b done=%b D=%h Bout=%b V=%b Z=%b want all 0",
                     bus.busy, bus.done, bus.D, bus.Bout, bus.V, bus.Z);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.busy) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrst_no_done got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, d;
        logic        bin, bout, v, z;
        int e, bn;
        for (int i = 0; i < 1000; i++) begin
            a   = $urandom;
            b   = (i % 10 == 0) ? a : $urandom;
            bin = 1'($urandom_range(0, 1));
            if (i % 7 == 0) a[31] = ~b[31];
            {bout, d} = {1'b0, a} - {1'b0, b} - {32'd0, bin};
            v = (a[31] ^ b[31]) & (d[31] ^ a[31]);
            z = (d == 32'd0);
            launch(a, b, bin, e, bn);
            checks++;
            if (e !== 8) begin
                errors++;
                $display("FAIL rnd%0d_latency got %0d want 8", i, e);
            end
            checks++;
            if ({bus.Bout, bus.D} !== {bout, d}) begin
                errors++;
                $display("FAIL rnd%0d_diff A=%h B=%h Bin=%b got %b_%h want %b_%h",
                         i, a, b, bin, bus.Bout, bus.D, bout, d);
            end
            checks++;
            if ({bus.V, bus.Z} !== {v, z}) begin
                errors++;
                $display("FAIL rnd%0d_VZ got %b%b want %b%b",
                         i, bus.V, bus.Z, v, z);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
